// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment message sequencer:
// glyph codes (gfedcba), the 42-entry glyph ROM and the sequencer state enum.
package seg7_pkg;

  localparam int unsigned NUM_GLYPHS = 42;

  // Hex digits
  localparam logic [6:0] ZERO  = 7'h3F;
  localparam logic [6:0] ONE   = 7'h06;
  localparam logic [6:0] TWO   = 7'h5B;
  localparam logic [6:0] THREE = 7'h4F;
  localparam logic [6:0] FOUR  = 7'h66;
  localparam logic [6:0] FIVE  = 7'h6D;
  localparam logic [6:0] SIX   = 7'h7D;
  localparam logic [6:0] SEVEN = 7'h07;
  localparam logic [6:0] EIGHT = 7'h7F;
  localparam logic [6:0] NINE  = 7'h6F;
  localparam logic [6:0] A     = 7'h77;
  localparam logic [6:0] B_L   = 7'h7C;
  localparam logic [6:0] C_U   = 7'h39;
  localparam logic [6:0] D_L   = 7'h5E;
  localparam logic [6:0] E     = 7'h79;
  localparam logic [6:0] F     = 7'h71;

  // Letters and symbols
  localparam logic [6:0] C_L   = 7'h58;
  localparam logic [6:0] G_L   = 7'h6F;
  localparam logic [6:0] H_U   = 7'h76;
  localparam logic [6:0] H_L   = 7'h74;
  localparam logic [6:0] I_L   = 7'h04;
  localparam logic [6:0] I_U   = 7'h30;
  localparam logic [6:0] J     = 7'h1E;
  localparam logic [6:0] L     = 7'h38;
  localparam logic [6:0] N_L   = 7'h54;
  localparam logic [6:0] O_U   = 7'h3F;
  localparam logic [6:0] O_L   = 7'h5C;
  localparam logic [6:0] P     = 7'h73;
  localparam logic [6:0] Q_L   = 7'h67;
  localparam logic [6:0] R_L   = 7'h50;
  localparam logic [6:0] S     = 7'h6D;
  localparam logic [6:0] T_L   = 7'h78;
  localparam logic [6:0] U     = 7'h3E;
  localparam logic [6:0] V_L   = 7'h1C;
  localparam logic [6:0] Y_L   = 7'h6E;
  localparam logic [6:0] GRAU  = 7'h63;

  localparam logic [6:0] GLYPH_ROM [NUM_GLYPHS] = '{
    ZERO, ONE, TWO, THREE, FOUR, FIVE, SIX, SEVEN,
    EIGHT, NINE, A, B_L, C_U, D_L, E, F,
    A, B_L, C_U, C_L, D_L, E, F, G_L,
    H_U, H_L, I_L, I_U, J, L, N_L, O_U,
    O_L, P, Q_L, R_L, S, T_L, U, V_L,
    Y_L, GRAU
  };

  localparam logic [5:0] BLANK_CHAR = 6'h3F;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} seq_state_t;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational glyph index -> 7-segment pattern lookup; unknown indices are blank.
module seg7_glyph
  import seg7_pkg::*;
#(
  parameter int unsigned NBITS_CHAR = 6
) (
  input  logic [NBITS_CHAR-1:0] glyph,
  output logic [6:0]            pattern_c
);

  always_comb begin
    pattern_c = '0;
    if (32'(glyph) < NUM_GLYPHS) pattern_c = GLYPH_ROM[glyph];
  end

endmodule

// File: rtl/seg7_msg_sequencer.sv
// Plays a stored glyph message on the 7-segment display with run/hold/step control.
// Optional SEG7_DP_MARK_EN lights the decimal point on the last character.
module seg7_msg_sequencer
  import seg7_pkg::*;
#(
  parameter int unsigned NBITS_TOP      = 8,
  parameter int unsigned NBITS_CHAR     = 6,
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned TICKS_PER_CHAR = 4
) (
  input  logic                       clk_2,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       step,
  input  logic [$clog2(DEPTH):0]     msg_len,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [NBITS_CHAR-1:0]      wr_char,
  output logic [NBITS_TOP-1:0]       SEG,
  output logic                       busy,
  output logic [$clog2(DEPTH)-1:0]   idx,
  output logic                       done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned TW = $clog2(TICKS_PER_CHAR + 1);

  logic [NBITS_CHAR-1:0] buffer [DEPTH];

  seq_state_t           state, state_nxt;
  logic [AW-1:0]        idx_nxt, adv_idx_c;
  logic [TW-1:0]        tick, tick_nxt;
  logic [LW-1:0]        len, len_nxt, start_len_c;
  logic                 done_nxt, busy_nxt, last_c, start_ok_c;
  logic [NBITS_TOP-1:0] seg_nxt;
  logic [6:0]           glyph_c;

  // Message buffer, writable in every state
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) buffer[i] <= NBITS_CHAR'(BLANK_CHAR);
    end else if (wr_en) begin
      buffer[wr_addr] <= wr_char;
    end
  end

  seg7_glyph #(.NBITS_CHAR(NBITS_CHAR)) u_glyph (
    .glyph     (buffer[idx]),
    .pattern_c (glyph_c)
  );

  assign last_c      = ({1'b0, idx} == len - LW'(1));
  assign adv_idx_c   = last_c ? '0 : idx + AW'(1);
  assign start_ok_c  = start && (msg_len != '0);
  assign start_len_c = (msg_len > LW'(DEPTH)) ? LW'(DEPTH) : msg_len;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      tick  <= '0;
      len   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
      SEG   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      tick  <= tick_nxt;
      len   <= len_nxt;
      done  <= done_nxt;
      busy  <= busy_nxt;
      SEG   <= seg_nxt;
    end
  end

  // Next state; priority start > pause > step > tick
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    tick_nxt  = tick;
    len_nxt   = len;
    done_nxt  = 1'b0;

    if (start_ok_c) begin
      state_nxt = RUN;
      idx_nxt   = '0;
      tick_nxt  = '0;
      len_nxt   = start_len_c;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (pause) begin
            state_nxt = HOLD;
          end else if (tick == TW'(TICKS_PER_CHAR - 1)) begin
            tick_nxt = '0;
            idx_nxt  = adv_idx_c;
            done_nxt = last_c;
          end else begin
            tick_nxt = tick + TW'(1);
          end
        end
        HOLD: begin
          if (!pause) begin
            state_nxt = RUN;
          end else if (step) begin
            tick_nxt = '0;
            idx_nxt  = adv_idx_c;
            done_nxt = last_c;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);

    // SEG follows buffer[idx] one cycle late and is dark while idle
    seg_nxt = '0;
    if (state != IDLE) begin
      seg_nxt[6:0] = glyph_c;
`ifdef SEG7_DP_MARK_EN
      seg_nxt[NBITS_TOP-1] = last_c;
`else
      seg_nxt[NBITS_TOP-1] = 1'b0;
`endif
    end
  end

endmodule
